// File: rtl/mcu_timer.sv
// mcu_timer: prescaled up/down timer with reload, one-shot,
// compare-driven PWM output and a sticky terminal-count irq.
module mcu_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             irq,
  output logic             pwm
);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_RELD = 2'd1;
  localparam logic [1:0] A_CMP  = 2'd2;
  localparam logic [1:0] A_PSC  = 2'd3;

  logic             en_q, en_d;
  logic             dir_q, dir_d;
  logic             os_q, os_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] reld_q, reld_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] plim_q, plim_d;
  logic [WIDTH-1:0] psc_q, psc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic wr_ctrl;
  logic start;
  logic stop;
  logic tick;
  logic at_end;
  logic term;

  // Decode writes and detect tick / terminal conditions
  always_comb begin
    wr_ctrl = wr_en && (wr_addr == A_CTRL);
    start   = wr_ctrl && wr_data[0] && !en_q;
    stop    = wr_ctrl && !wr_data[0];
    tick    = en_q && (psc_q == plim_q);
    at_end  = dir_q ? (cnt_q == '0)
                    : (cnt_q >= reld_q);
    // A disabling write on a tick cycle suppresses the advance
    term    = tick && at_end && !stop;
  end

  // Next-state for configuration, prescaler, counter and irq
  always_comb begin
    en_d   = en_q;
    dir_d  = dir_q;
    os_d   = os_q;
    reld_d = reld_q;
    cmp_d  = cmp_q;
    plim_d = plim_q;
    cnt_d  = cnt_q;
    irq_d  = irq_q;

    if (term && os_q)
      en_d = 1'b0;

    if (wr_en) begin
      unique case (wr_addr)
        A_CTRL: begin
          en_d  = wr_data[0];
          dir_d = wr_data[1];
          os_d  = wr_data[2];
        end
        A_RELD: reld_d = wr_data;
        A_CMP:  cmp_d  = wr_data;
        A_PSC:  plim_d = wr_data;
        default: ;
      endcase
    end

    unique case (1'b1)
      start:
        cnt_d = wr_data[1] ? reld_q : '0;
      tick && !stop: begin
        if (at_end)
          cnt_d = dir_q ? reld_q : '0;
        else if (dir_q)
          cnt_d = cnt_q - 1'b1;
        else
          cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase

    psc_d = (!en_d || start || tick) ? '0
                                     : psc_q + 1'b1;

    if (wr_ctrl && wr_data[3])
      irq_d = 1'b0;
    if (term)
      irq_d = 1'b1;
  end

  // State registers, cleared while reset is high
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      en_q   <= 1'b0;
      dir_q  <= 1'b0;
      os_q   <= 1'b0;
      irq_q  <= 1'b0;
      reld_q <= '0;
      cmp_q  <= '0;
      plim_q <= '0;
      psc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      en_q   <= en_d;
      dir_q  <= dir_d;
      os_q   <= os_d;
      irq_q  <= irq_d;
      reld_q <= reld_d;
      cmp_q  <= cmp_d;
      plim_q <= plim_d;
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs straight from registers
  always_comb begin
    count   = cnt_q;
    running = en_q;
    irq     = irq_q;
    pwm     = en_q && (cnt_q < cmp_q);
  end

endmodule

// File: tb/tb_mcu_timer.sv
// tb_mcu_timer: scoreboard bench for mcu_timer.
// Expected outputs are queued per cycle and popped after the edge.
module tb_mcu_timer;

  typedef struct packed {
    logic [7:0] c;
    logic       r;
    logic       i;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] count;
  logic       running;
  logic       irq;
  logic       pwm;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  mcu_timer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .count   (count),
    .running (running),
    .irq     (irq),
    .pwm     (pwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_cnt"}, count, e.c);
    chk({tag, "_run"}, running, e.r);
    chk({tag, "_irq"}, irq, e.i);
    chk({tag, "_pwm"}, pwm, e.p);
  endtask

  // one clock with optional write, then compare queued result
  task automatic step(input string tag,
                      input logic we,
                      input logic [1:0] a,
                      input logic [7:0] d,
                      input logic [7:0] ec,
                      input logic er,
                      input logic ei,
                      input logic ep);
    exp_t e;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    e.c = ec; e.r = er; e.i = ei; e.p = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    pop_cmp(tag);
  endtask

  task automatic idle(input string tag,
                      input logic [7:0] ec,
                      input logic er,
                      input logic ei,
                      input logic ep);
    step(tag, 1'b0, 2'd0, 8'd0, ec, er, ei, ep);
  endtask

  initial begin
    exp_t e;
    int   hi;
    int   k;
    logic [7:0] c;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    e = '0;
    sb.push_back(e);
    pop_cmp("rst");
    rst_n = 1'b0;

    // up periodic, RELOAD=3
    step("u_rl", 1, 2'd1, 8'd3, 0, 0, 0, 0);
    step("u_en", 1, 2'd0, 8'h01, 0, 1, 0, 0);
    idle("u1", 1, 1, 0, 0);
    idle("u2", 2, 1, 0, 0);
    idle("u3", 3, 1, 0, 0);
    idle("u_wrap", 0, 1, 1, 0);
    idle("u_stk", 1, 1, 1, 0);
    step("u_clr", 1, 2'd0, 8'h09, 2, 1, 0, 0);
    idle("u4", 3, 1, 0, 0);
    idle("u_wrap2", 0, 1, 1, 0);
    idle("u5", 1, 1, 1, 0);
    step("u_dis_tick", 1, 2'd0, 8'h00, 1, 0, 1, 0);
    idle("u_frz", 1, 0, 1, 0);
    step("u_clr2", 1, 2'd0, 8'h08, 1, 0, 0, 0);

    // terminal tick coinciding with irq_clr
    step("s_en", 1, 2'd0, 8'h01, 0, 1, 0, 0);
    idle("s1", 1, 1, 0, 0);
    idle("s2", 2, 1, 0, 0);
    idle("s3", 3, 1, 0, 0);
    step("s_setwin", 1, 2'd0, 8'h09, 0, 1, 1, 0);
    step("s_dis", 1, 2'd0, 8'h08, 0, 0, 0, 0);

    // prescale + pwm: PRESCALE=1 RELOAD=9 COMPARE=3
    step("p_psc", 1, 2'd3, 8'd1, 0, 0, 0, 0);
    step("p_rl", 1, 2'd1, 8'd9, 0, 0, 0, 0);
    step("p_cmp", 1, 2'd2, 8'd3, 0, 0, 0, 0);
    hi = 0;
    for (int j = 0; j < 40; j++) begin
      c = 8'((j / 2) % 10);
      if (j < 20 && c < 3) hi++;
      step("p_seq", j == 0, 2'd0, 8'h01,
           c, 1, j >= 20, c < 3);
      if (j < 20 && pwm) hi--;
    end
    chk("p_pwm_hi_balance", hi, 0);
    idle("p40", 0, 1, 1, 1);
    step("p_clr", 1, 2'd0, 8'h09, 0, 1, 0, 1);
    for (k = 42; k <= 54; k++) begin
      c = 8'((k / 2) % 10);
      idle("p_run", c, 1, 0, c < 3);
    end
    // live RELOAD change on a non-tick cycle at count 7
    step("l_rl4", 1, 2'd1, 8'd4, 7, 1, 0, 0);
    idle("l_wrap", 0, 1, 1, 1);
    idle("l_hold", 0, 1, 1, 1);
    idle("l_adv", 1, 1, 1, 1);

    // down oneshot, RELOAD=5
    step("d_dis", 1, 2'd0, 8'h00, 1, 0, 1, 0);
    step("d_psc", 1, 2'd3, 8'd0, 1, 0, 1, 0);
    step("d_rl", 1, 2'd1, 8'd5, 1, 0, 1, 0);
    step("d_clr", 1, 2'd0, 8'h08, 1, 0, 0, 0);
    step("d_en", 1, 2'd0, 8'h07, 5, 1, 0, 0);
    idle("d4", 4, 1, 0, 0);
    idle("d3", 3, 1, 0, 0);
    idle("d2", 2, 1, 0, 1);
    idle("d1", 1, 1, 0, 1);
    idle("d0", 0, 1, 0, 1);
    idle("d_term", 5, 0, 1, 0);
    idle("d_hold1", 5, 0, 1, 0);
    idle("d_hold2", 5, 0, 1, 0);

    // reset mid-operation
    step("r_en", 1, 2'd0, 8'h01, 0, 1, 1, 1);
    idle("r1", 1, 1, 1, 1);
    idle("r2", 2, 1, 1, 1);
    #2;
    rst_n = 1'b1;
    #1;
    e = '0;
    sb.push_back(e);
    pop_cmp("r_async");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle("r_idle1", 0, 0, 0, 0);
    idle("r_idle2", 0, 0, 0, 0);
    // registers cleared: RELOAD=0 wraps every tick
    step("r_reen", 1, 2'd0, 8'h01, 0, 1, 0, 0);
    idle("r_wrap", 0, 1, 1, 0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
